lcd_bus_master: RTL and testbench

- Clocked HD44780-style character-LCD bus initiator with read-back.
- Replaces direct MCU-bus pass-through of E/RS/RW with generated timing.
- Accepts commands over a valid/ready handshake and drives RS/RW/E/data with programmable setup, pulse and cycle times.
- Captures read data and optionally polls the busy flag (DB7) until clear, so the MCU never spins on slow LCD operations.

---
 rtl/lcd_bus_master_if.sv | 35 +++
 rtl/lcd_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_lcd_bus_master.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_master_if.sv
// Command/response handshake and HD44780-style pad signals of the LCD bus initiator.
// The LCD bus master uses the "master" modport. The command source and the LCD pads use "slave".
interface lcd_bus_master_if;
  // A command transfers on the clock edge where cmd_valid_i && cmd_ready_o.
  // After cmd_valid_i is raised, the command source holds it and the cmd fields stable until that edge.
  // The master only raises cmd_ready_o while idle.
  // rsp_valid_o and timeout_o are single-cycle pulses with no back-pressure.
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_rs_i;
  logic       cmd_rw_i;
  logic       cmd_poll_i;
  logic [7:0] cmd_dat_i8;
  logic       rsp_valid_o;
  logic [7:0] rsp_dat_o8;
  logic       timeout_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_e_o;
  logic [7:0] lcd_dat_o8;
  logic       lcd_dat_oe_o;
  logic [7:0] lcd_dat_i8;

  modport master (
    input  cmd_valid_i, cmd_rs_i, cmd_rw_i, cmd_poll_i, cmd_dat_i8, lcd_dat_i8,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o8, timeout_o,
           lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_dat_o8, lcd_dat_oe_o
  );

  modport slave (
    output cmd_valid_i, cmd_rs_i, cmd_rw_i, cmd_poll_i, cmd_dat_i8, lcd_dat_i8,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o8, timeout_o,
           lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_dat_o8, lcd_dat_oe_o
  );
endinterface

// File: rtl/lcd_bus_master.sv
// HD44780-style LCD bus initiator. It generates setup, E-pulse and cycle timing from a command,
// captures read data, and can optionally poll the busy flag (DB7) until it clears or times out.
module lcd_bus_master #(
  parameter int T_AS     = 2,
  parameter int T_EW     = 12,
  parameter int T_CYC    = 24,
  parameter int POLL_MAX = 65535
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  lcd_bus_master_if.master  bus,
  output logic [2:0]        dbg_state_o
);

  localparam int CW = $clog2(T_CYC + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [CW-1:0] E_RISE    = CW'(T_AS);
  localparam logic [CW-1:0] E_FALL    = CW'(T_AS + T_EW);
  localparam logic [CW-1:0] T_END     = CW'(T_CYC);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    EHIGH  = 3'd2,
    EHOLD  = 3'd3,
    PSETUP = 3'd4,
    PEHIGH = 3'd5,
    PEHOLD = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          rw_q, rw_d;
  logic          poll_q, poll_d;
  logic [7:0]    cap_q, cap_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic          lrw_q, lrw_d;
  logic [7:0]    dat_q, dat_d;
  logic          oe_q, oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          timeout_q, timeout_d;
  logic          start_poll;
  logic          finish;
  logic [CW-1:0] edge_num;

  // cyc_q holds the index of the last edge taken since the transaction started.
  // The edge being evaluated is therefore one later.
  assign edge_num = cyc_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + CW'(1);
    poll_cnt_d  = poll_cnt_q;
    rw_d        = rw_q;
    poll_d      = poll_q;
    cap_d       = cap_q;
    e_d         = e_q;
    rs_d        = rs_q;
    lrw_d       = lrw_q;
    dat_d       = dat_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    timeout_d   = 1'b0;
    start_poll  = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (bus.cmd_valid_i) begin
          state_d    = SETUP;
          rw_d       = bus.cmd_rw_i;
          poll_d     = bus.cmd_poll_i;
          poll_cnt_d = '0;
          rs_d       = bus.cmd_rs_i;
          lrw_d      = bus.cmd_rw_i;
          oe_d       = ~bus.cmd_rw_i;
          if (!bus.cmd_rw_i) dat_d = bus.cmd_dat_i8;
        end
      end
      SETUP, PSETUP: begin
        if (edge_num == E_RISE) begin
          e_d     = 1'b1;
          state_d = (state_q == SETUP) ? EHIGH : PEHIGH;
        end
      end
      EHIGH, PEHIGH: begin
        if (edge_num == E_FALL) begin
          e_d     = 1'b0;
          cap_d   = bus.lcd_dat_i8;
          state_d = (state_q == EHIGH) ? EHOLD : PEHOLD;
        end
      end
      EHOLD: begin
        if (edge_num == T_END) begin
          if (rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = cap_q;
          end
          start_poll = poll_q;
          finish     = ~poll_q;
        end
      end
      PEHOLD: begin
        if (edge_num == T_END) begin
          poll_cnt_d = poll_cnt_q + PW'(1);
          if (!cap_q[7]) begin
            finish = 1'b1;
          end else if (poll_cnt_q == POLL_LAST) begin
            timeout_d = 1'b1;
            finish    = 1'b1;
          end else begin
            start_poll = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A poll reads the instruction register: RS=0, RW=1, and the pads are released.
    if (start_poll) begin
      state_d = PSETUP;
      cyc_d   = '0;
      rs_d    = 1'b0;
      lrw_d   = 1'b1;
      oe_d    = 1'b0;
    end
    if (finish) begin
      state_d = IDLE;
      cyc_d   = '0;
      lrw_d   = 1'b1;
      oe_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      poll_cnt_q  <= '0;
      rw_q        <= 1'b0;
      poll_q      <= 1'b0;
      cap_q       <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      lrw_q       <= 1'b1;
      dat_q       <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      poll_cnt_q  <= poll_cnt_d;
      rw_q        <= rw_d;
      poll_q      <= poll_d;
      cap_q       <= cap_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      lrw_q       <= lrw_d;
      dat_q       <= dat_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o8   = rsp_dat_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.lcd_rs_o     = rs_q;
  assign bus.lcd_rw_o     = lrw_q;
  assign bus.lcd_e_o      = e_q;
  assign bus.lcd_dat_o8   = dat_q;
  assign bus.lcd_dat_oe_o = oe_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_lcd_bus_master.sv
// Self-checking bench for lcd_bus_master. It applies table vectors, randomized commands and a
// mid-transaction reset, and compares each cycle against a segment/offset timing model.
module tb_lcd_bus_master;
  localparam int T_AS     = 2;
  localparam int T_EW     = 12;
  localparam int T_CYC    = 24;
  localparam int POLL_MAX = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  lcd_bus_master_if bus();

  lcd_bus_master #(
    .T_AS(T_AS), .T_EW(T_EW), .T_CYC(T_CYC), .POLL_MAX(POLL_MAX)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rs;
    logic       rw;
    logic       poll;
    logic [7:0] dat;
    logic [7:0] rd;
    logic [7:0] exp_rsp;
    int         busy;
    int         exp_total;
    logic       exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_rs_i    = 1'b0;
    bus.cmd_rw_i    = 1'b0;
    bus.cmd_poll_i  = 1'b0;
    bus.cmd_dat_i8  = 8'h00;
    bus.lcd_dat_i8  = 8'($urandom);
  endtask

  // The model splits the run into T_CYC-long segments: segment 0 is the command and
  // segments 1..n are busy polls. The output values follow from segment number and offset.
  task automatic run_cmd(input logic rs, input logic rw, input logic poll,
                         input logic [7:0] dat, input logic [7:0] rd, input logic [7:0] exp_rsp,
                         input int busy, input int total, input logic to, input string tag);
    int   seg;
    int   off;
    logic e_x, rdy_x, rs_x, rw_x, oe_x, rv_x, to_x;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_rs_i    = rs;
    bus.cmd_rw_i    = rw;
    bus.cmd_poll_i  = poll;
    bus.cmd_dat_i8  = dat;
    bus.lcd_dat_i8  = 8'($urandom);
    if (rw) exp_q.push_back(exp_rsp);
    for (int k = 0; k <= total + 1; k++) begin
      tick();
      seg = k / T_CYC;
      off = k % T_CYC;
      if (k < total) begin
        e_x   = (off >= T_AS) && (off < T_AS + T_EW);
        rdy_x = 1'b0;
        rs_x  = (seg == 0) ? rs : 1'b0;
        rw_x  = (seg == 0) ? rw : 1'b1;
        oe_x  = (seg == 0) && !rw;
      end else begin
        e_x   = 1'b0;
        rdy_x = 1'b1;
        rs_x  = 1'b0;
        rw_x  = 1'b1;
        oe_x  = 1'b0;
      end
      rv_x = rw && (k == T_CYC);
      to_x = to && (k == total);
      check($sformatf("%s ctl k=%0d {rdy,e,rw,oe,rv,to}", tag, k),
            32'({bus.cmd_ready_o, bus.lcd_e_o, bus.lcd_rw_o, bus.lcd_dat_oe_o,
                 bus.rsp_valid_o, bus.timeout_o}),
            32'({rdy_x, e_x, rw_x, oe_x, rv_x, to_x}));
      if (k < total) check($sformatf("%s rs k=%0d", tag, k), 32'(bus.lcd_rs_o), 32'(rs_x));
      if (oe_x) check($sformatf("%s dat k=%0d", tag, k), 32'(bus.lcd_dat_o8), 32'(dat));
      if (bus.rsp_valid_o && exp_q.size() > 0)
        check($sformatf("%s rsp_dat", tag), 32'(bus.rsp_dat_o8), 32'(exp_q.pop_front()));
      // Unrelated junk commands arrive while the master is busy and must be ignored.
      if (k < total - 1 && $urandom_range(0, 1) == 1) begin
        bus.cmd_valid_i = 1'b1;
        bus.cmd_rs_i    = 1'($urandom);
        bus.cmd_rw_i    = 1'($urandom);
        bus.cmd_poll_i  = 1'($urandom);
        bus.cmd_dat_i8  = 8'($urandom);
      end else begin
        bus.cmd_valid_i = 1'b0;
      end
      if (k < total && off >= T_AS && off < T_AS + T_EW) begin
        if (seg == 0) bus.lcd_dat_i8 = rd;
        else if (seg <= busy) bus.lcd_dat_i8 = {1'b1, 7'($urandom)};
        else bus.lcd_dat_i8 = {1'b0, 7'($urandom)};
      end else begin
        bus.lcd_dat_i8 = 8'($urandom);
      end
    end
  endtask

  vec_t       vecs[6];
  logic       r_rs, r_rw, r_poll, r_to;
  logic [7:0] r_dat, r_rd;
  int         r_busy, r_n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h38, 8'h00, 8'h00, 0, 24, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h5A, 0, 24, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 3, 120, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 10, 120, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 8'hC3, 1, 72, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'hA7, 8'h00, 8'h00, 0, 48, 1'b0};

    // Reset values while reset is held across several edges.
    drive_idle();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst ctl {rdy,e,rw,oe,rv,to}",
          32'({bus.cmd_ready_o, bus.lcd_e_o, bus.lcd_rw_o, bus.lcd_dat_oe_o,
               bus.rsp_valid_o, bus.timeout_o}), 32'(6'b101000));
    check("rst rs", 32'(bus.lcd_rs_o), 32'(0));
    check("rst lcd_dat", 32'(bus.lcd_dat_o8), 32'(0));
    check("rst rsp_dat", 32'(bus.rsp_dat_o8), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst ready", 32'(bus.cmd_ready_o), 32'(1));

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].rs, vecs[i].rw, vecs[i].poll, vecs[i].dat, vecs[i].rd, vecs[i].exp_rsp,
              vecs[i].busy, vecs[i].exp_total, vecs[i].exp_to, $sformatf("vec%0d", i));

    // Reset while E is high: E drops at once, no response or timeout ever follows.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_rs_i    = 1'b1;
    bus.cmd_rw_i    = 1'b1;
    bus.cmd_poll_i  = 1'b1;
    bus.cmd_dat_i8  = 8'h00;
    bus.lcd_dat_i8  = 8'hFF;
    for (int k = 0; k <= 6; k++) begin
      tick();
      bus.cmd_valid_i = 1'b0;
    end
    check("mid e_high before reset", 32'(bus.lcd_e_o), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst {rdy,e,oe}",
          32'({bus.cmd_ready_o, bus.lcd_e_o, bus.lcd_dat_oe_o}), 32'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * T_CYC; k++) begin
      tick();
      check($sformatf("after_rst k=%0d {rdy,e,rv,to}", k),
            32'({bus.cmd_ready_o, bus.lcd_e_o, bus.rsp_valid_o, bus.timeout_o}), 32'(4'b1000));
    end

    // Randomized commands checked against the reference rules.
    for (int i = 0; i < 8; i++) begin
      r_rs   = 1'($urandom);
      r_rw   = 1'($urandom);
      r_poll = 1'($urandom);
      r_dat  = 8'($urandom);
      r_rd   = 8'($urandom);
      r_busy = $urandom_range(0, 5);
      r_n    = !r_poll ? 0 : ((r_busy >= POLL_MAX) ? POLL_MAX : r_busy + 1);
      r_to   = r_poll && (r_busy >= POLL_MAX);
      run_cmd(r_rs, r_rw, r_poll, r_dat, r_rd, r_rd, r_busy, (1 + r_n) * T_CYC, r_to,
              $sformatf("rnd%0d", i));
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
